// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown-timer control stage.
// The optional TIMER_AUTO_RELOAD_EN build keeps the timer in RUN across expiries.
package timer_pkg;

  localparam int INIT_W = 9;

  localparam int TICK_DIV_DEF     = 100_000_000;
  localparam int DEB_LEN_DEF      = 4;
  localparam int INIT_DEFAULT_DEF = 59;
  localparam int INIT_MAX_DEF     = 59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Preset increment that wraps back to zero past the largest selectable value.
  function automatic logic [INIT_W-1:0] init_step(
    input logic [INIT_W-1:0] cur,
    input logic [INIT_W-1:0] max_v
  );
    return (cur >= max_v) ? '0 : cur + INIT_W'(1);
  endfunction

endpackage

// File: rtl/timer_ctrl_btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter, one-cycle press pulse.
// Raw-to-pulse latency is DEB_LEN+2 cycles; a held button yields exactly one pulse.
module btn_cond #(
  parameter int DEB_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_p
);

  localparam int              CNT_W   = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEB_LEN - 1);

  logic             sync0_q;
  logic             sync1_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             pulse_q;
  logic             pulse_d;

  // cnt_q saturates at DEB_LEN-1 samples seen; the next high sample accepts the press.
  always_comb begin
    cnt_d   = '0;
    level_d = 1'b0;
    if (sync1_q) begin
      level_d = (cnt_q == CNT_TOP);
      cnt_d   = level_d ? cnt_q : cnt_q + CNT_W'(1);
    end
    pulse_d = level_d && !level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync0_q <= btn_raw;
      sync1_q <= sync0_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_p = pulse_q;

endmodule

// File: rtl/timer_ctrl.sv
// Timer control: button conditioning, count tick, run/pause/done FSM and preset register.
// TIMER_AUTO_RELOAD_EN: expiry stays in RUN and done_led becomes a one-cycle pulse.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int DEB_LEN      = DEB_LEN_DEF,
  parameter int INIT_DEFAULT = INIT_DEFAULT_DEF,
  parameter int INIT_MAX     = INIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic              btn_reset,
  input  logic              btn_inc,
  input  logic              borrow_in,
  output logic              count_en,
  output logic              reset_en,
  output logic [INIT_W-1:0] init,
  output logic [1:0]        state,
  output logic              done_led
);

  localparam int                TCNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCNT_W-1:0] TCNT_TOP = TCNT_W'(TICK_DIV - 1);

  logic start_p;
  logic reset_p;
  logic inc_p;

  btn_cond #(.DEB_LEN(DEB_LEN)) u_btn_start (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start),
    .press_p (start_p)
  );

  btn_cond #(.DEB_LEN(DEB_LEN)) u_btn_reset (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_reset),
    .press_p (reset_p)
  );

  btn_cond #(.DEB_LEN(DEB_LEN)) u_btn_inc (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_inc),
    .press_p (inc_p)
  );

  state_e            state_q;
  state_e            state_d;
  logic [INIT_W-1:0] init_q;
  logic [INIT_W-1:0] init_d;
  logic [TCNT_W-1:0] tcnt_q;
  logic [TCNT_W-1:0] tcnt_d;
  logic              tick_q;
  logic              tick_d;
  logic              expiry;

  assign count_en = tick_q && (state_q == ST_RUN);
  assign reset_en = (state_q == ST_IDLE);
  assign expiry   = count_en && borrow_in;

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    case (state_q)
      ST_IDLE: begin
        if (reset_p) begin
          state_d = ST_IDLE;
        end else if (start_p) begin
          state_d = ST_RUN;
        end else if (inc_p) begin
          init_d = init_step(init_q, INIT_W'(INIT_MAX));
        end
      end
      ST_RUN: begin
        if (reset_p) begin
          state_d = ST_IDLE;
        end else if (expiry) begin
`ifdef TIMER_AUTO_RELOAD_EN
          state_d = ST_RUN;
`else
          state_d = ST_DONE;
`endif
        end else if (start_p) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (reset_p) begin
          state_d = ST_IDLE;
        end else if (start_p) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (reset_p) begin
          state_d = ST_IDLE;
        end else if (start_p) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PAUSE freezes tcnt so a resumed run finishes the interrupted tick period.
  always_comb begin
    tcnt_d = '0;
    tick_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        tick_d = (tcnt_q == TCNT_TOP);
        tcnt_d = tick_d ? '0 : tcnt_q + TCNT_W'(1);
      end
      ST_PAUSE: tcnt_d = tcnt_q;
      default:  tcnt_d = '0;
    endcase
  end

`ifdef TIMER_AUTO_RELOAD_EN
  logic done_q;
  logic done_d;

  // Pulse only on an expiry that actually wins arbitration against a reset press.
  assign done_d = (state_q == ST_RUN) && !reset_p && expiry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done_led = done_q;
`else
  assign done_led = (state_q == ST_DONE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      init_q  <= INIT_W'(INIT_DEFAULT);
      tcnt_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      tcnt_q  <= tcnt_d;
      tick_q  <= tick_d;
    end
  end

  assign state = state_q;
  assign init  = init_q;

endmodule
